// File: rtl/output_pkg.sv
// output_pkg: shared state type and index helpers for the output collector.
package output_pkg;

    typedef enum logic {IDLE, CAPTURE} state_e;

    function automatic int phase_w(int cols);
        return cols > 1 ? $clog2(cols) : 1;
    endfunction

    function automatic int ptr_w(int depth);
        return $clog2(depth);
    endfunction

    function automatic int pe_index(int r, int c, int rows, int cols, int dw);
        return dw * (rows * cols - r * cols - c) - 1;
    endfunction

    // Reducing r first keeps the sum small when ROWS > COLS.
    function automatic int rot_col(int p, int r, int cols);
        return (p + r % cols) % cols;
    endfunction

endpackage

// File: rtl/output_fifo.sv
// output_fifo: single-clock FIFO with wrap-bit pointers; a full FIFO accepts a push only alongside a pop.
module output_fifo import output_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = ptr_w(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0] wr_q, rd_q;
    logic wr_en, rd_en;
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full_o || rd_en);
    assign rdata_o = mem_q[rd_q[PW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + {{PW{1'b0}}, wr_en};
            rd_q <= rd_q + {{PW{1'b0}}, rd_en};
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[PW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/output_collector.sv
// output_collector: sweeps the rotating completion diagonal of the PE array into a
// FIFO of row-vectors tagged with phase and last-of-tile, drained over valid/ready.
module output_collector import output_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int FIFO_DEPTH = 8,
    localparam int PHASE_W   = phase_w(COLS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [DATA_WIDTH*ROWS*COLS-1:0]  pe_data,
    output logic [DATA_WIDTH*ROWS-1:0]       out_data,
    output logic [PHASE_W-1:0]               out_col,
    output logic                             out_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             overflow,
    input  logic                             overflow_clr
);
    localparam int WW = DATA_WIDTH * ROWS + PHASE_W + 1;
    localparam int IW = $clog2(DATA_WIDTH * ROWS * COLS);
    state_e state_q, state_d;
    logic [PHASE_W-1:0] p_q, p_d;
    logic overflow_q, overflow_d;
    logic cap, last, pop, full, empty;
    logic [DATA_WIDTH*ROWS-1:0] lanes;
    logic [WW-1:0] head;
    assign cap  = state_q == CAPTURE || start;
    assign last = p_q == PHASE_W'(COLS - 1);
    assign pop  = out_ready && !empty;
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [IW-1:0] idx;
        assign idx = IW'(pe_index(r, rot_col(int'(p_q), r, COLS), ROWS, COLS, DATA_WIDTH));
        assign lanes[DATA_WIDTH*(ROWS-r)-1 -: DATA_WIDTH] = pe_data[idx -: DATA_WIDTH];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            p_q        <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            overflow_q <= overflow_d;
        end
    end
    // A tile ends at the last phase unless a new start chains the next tile on.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        if (cap) begin
            p_d     = last ? '0 : p_q + 1'b1;
            state_d = (!last || (state_q == CAPTURE && start)) ? CAPTURE : IDLE;
        end
    end
    always_comb begin
        overflow_d = (cap && full && !pop) ? 1'b1 : overflow_clr ? 1'b0 : overflow_q;
        out_valid  = !empty;
        {out_data, out_col, out_last} = out_valid ? head : '0;
        busy       = state_q == CAPTURE || !empty;
        overflow   = overflow_q;
    end
    output_fifo #(.WIDTH(WW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cap),
        .pop_i   (pop),
        .wdata_i ({lanes, p_q, last}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );
endmodule

// File: tb/tb_output_collector.sv
// tb_output_collector: directed table-driven checks plus multi-cycle corner sequences.
module tb_output_collector;
    localparam int DW = 8, C = 4, D = 8;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;
    logic start = 0, ready = 0, clr = 0, start_b = 0;
    logic [DW*4*C-1:0] pe_a;
    logic [DW*6*C-1:0] pe_b;
    logic [DW*4-1:0] data_a;
    logic [DW*6-1:0] data_b;
    logic [1:0] col_a, col_b;
    logic last_a, valid_a, busy_a, ovf_a;
    logic last_b, valid_b, busy_b, ovf_b;
    int total = 0, bad = 0;

    output_collector #(.DATA_WIDTH(DW), .ROWS(4), .COLS(C), .FIFO_DEPTH(D)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .pe_data(pe_a),
        .out_data(data_a), .out_col(col_a), .out_last(last_a), .out_valid(valid_a),
        .out_ready(ready), .busy(busy_a), .overflow(ovf_a), .overflow_clr(clr));

    output_collector #(.DATA_WIDTH(DW), .ROWS(6), .COLS(C), .FIFO_DEPTH(D)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .pe_data(pe_b),
        .out_data(data_b), .out_col(col_b), .out_last(last_b), .out_valid(valid_b),
        .out_ready(1'b1), .busy(busy_b), .overflow(ovf_b), .overflow_clr(1'b0));

    typedef struct {
        logic st;
        logic rd;
        logic v;
        int   col;
        logic last;
        logic busy;
    } vec_t;
    vec_t tbl[14];

    function automatic logic [63:0] exp_word(int rows, int p);
        logic [63:0] w = '0;
        for (int r = 0; r < rows; r++) w = (w << 8) | 64'(16 * r + (p + r) % 4);
        return w;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(string nm, int p);
        chk({nm, " valid"}, 64'(valid_a), 1);
        chk({nm, " col"}, 64'(col_a), 64'(p));
        chk({nm, " last"}, 64'(last_a), 64'(p == 3));
        chk({nm, " data"}, 64'(data_a), exp_word(4, p));
    endtask

    initial begin
        int n;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < C; c++) pe_a[DW*(4*C - r*C - c)-1 -: DW] = 8'(16 * r + c);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < C; c++) pe_b[DW*(6*C - r*C - c)-1 -: DW] = 8'(16 * r + c);
        tbl = '{
            '{1, 1, 1, 0, 0, 1}, '{0, 1, 1, 1, 0, 1}, '{0, 1, 1, 2, 0, 1}, '{0, 1, 1, 3, 1, 1},
            '{0, 1, 0, 0, 0, 0},
            '{1, 1, 1, 0, 0, 1}, '{0, 1, 1, 1, 0, 1}, '{0, 1, 1, 2, 0, 1}, '{1, 1, 1, 3, 1, 1},
            '{0, 1, 1, 0, 0, 1}, '{0, 1, 1, 1, 0, 1}, '{0, 1, 1, 2, 0, 1}, '{0, 1, 1, 3, 1, 1},
            '{0, 1, 0, 0, 0, 0}
        };
        // Reset, with start asserted while reset is held.
        start = 1;
        step();
        step();
        chk("rst valid", 64'(valid_a), 0);
        chk("rst data", 64'(data_a), 0);
        chk("rst col", 64'(col_a), 0);
        chk("rst last", 64'(last_a), 0);
        chk("rst busy", 64'(busy_a), 0);
        chk("rst ovf", 64'(ovf_a), 0);
        rst_n = 1;
        start = 0;
        step();
        chk("post-rst idle", 64'(valid_a), 0);
        // Single tile then back-to-back tiles.
        for (int i = 0; i < 14; i++) begin
            start = tbl[i].st;
            ready = tbl[i].rd;
            step();
            chk($sformatf("tbl%0d valid", i), 64'(valid_a), 64'(tbl[i].v));
            chk($sformatf("tbl%0d col", i), 64'(col_a), 64'(tbl[i].col));
            chk($sformatf("tbl%0d last", i), 64'(last_a), 64'(tbl[i].last));
            chk($sformatf("tbl%0d busy", i), 64'(busy_a), 64'(tbl[i].busy));
            chk($sformatf("tbl%0d data", i), 64'(data_a), tbl[i].v ? exp_word(4, tbl[i].col) : 64'd0);
        end
        start = 0;
        // Back-pressure over three tiles: 8 kept, 4 dropped.
        ready = 0;
        for (int i = 0; i < 12; i++) begin
            start = (i % 4 == 0);
            step();
        end
        start = 0;
        chk("bp ovf", 64'(ovf_a), 1);
        chk_head("bp head", 0);
        step();
        chk_head("bp stable", 0);
        ready = 1;
        for (int k = 0; k < 8; k++) begin
            chk_head($sformatf("bp drain%0d", k), k % 4);
            step();
        end
        chk("bp empty", 64'(valid_a), 0);
        chk("bp ovf sticky", 64'(ovf_a), 1);
        clr = 1;
        step();
        clr = 0;
        chk("ovf clr", 64'(ovf_a), 0);
        // Full FIFO with simultaneous push and pop.
        ready = 0;
        for (int i = 0; i < 8; i++) begin
            start = (i % 4 == 0);
            step();
        end
        ready = 1;
        for (int i = 0; i < 4; i++) begin
            start = (i == 0);
            step();
        end
        start = 0;
        chk("full pushpop ovf", 64'(ovf_a), 0);
        n = 0;
        for (int i = 0; i < 20 && valid_a; i++) begin
            n++;
            step();
        end
        chk("full drain count", 64'(n), 8);
        // Reset mid-tile with words queued.
        ready = 0;
        start = 1;
        step();
        start = 0;
        step();
        chk("pre-rst valid", 64'(valid_a), 1);
        rst_n = 0;
        start = 1;
        #1;
        chk("async rst valid", 64'(valid_a), 0);
        chk("async rst busy", 64'(busy_a), 0);
        chk("async rst ovf", 64'(ovf_a), 0);
        step();
        rst_n = 1;
        start = 0;
        step();
        chk("rst start ignored", 64'(valid_a), 0);
        ready = 1;
        start = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            start = 0;
            chk_head($sformatf("after rst%0d", k), k);
        end
        step();
        chk("after rst busy", 64'(busy_a), 0);
        // Non-square 6x4 array.
        start_b = 1;
        step();
        start_b = 0;
        chk("ns lane5 p0", 64'(data_b[7:0]), 64'h51);
        chk("ns data p0", 64'(data_b), exp_word(6, 0));
        step();
        step();
        step();
        chk("ns col p3", 64'(col_b), 3);
        chk("ns lane4 p3", 64'(data_b[15:8]), 64'h43);
        chk("ns data p3", 64'(data_b), exp_word(6, 3));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
